// File: rtl/failover_ctrl_pkg.sv
// Shared types and helpers for the dual-link failover controller.
// Holds the FSM encoding, counter widths and want-port priority logic.
package failover_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_HOLD   = 2'd1,
    ST_DRAIN  = 2'd2
  } fsm_state_t;

  localparam int CNT_W    = 32;
  localparam int SW_CNT_W = 16;

  function automatic logic want_sel(
    input logic force_en,
    input logic force_sel,
    input logic ok1,
    input logic ok2,
    input logic revert_on,
    input logic cur_sel
  );
    logic w;
    w = cur_sel;
    priority case (1'b1)
      force_en:                  w = force_sel;
      (!ok1 && ok2):             w = 1'b1;
      (ok1 && !ok2):             w = 1'b0;
      (ok1 && ok2 && revert_on): w = 1'b0;
      default:                   w = cur_sel;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/failover_ctrl_idle_gap.sv
// Idle-gap timer: counts consecutive all-idle cycles.
// done flags the final idle cycle of the required gap.
module idle_gap_timer
  import failover_ctrl_pkg::*;
#(
  parameter int GAP_CYCLES = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic busy,
  output logic done
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(GAP_CYCLES - 1);

  logic [CNT_W-1:0] gap_cnt;

  assign done = !busy && (gap_cnt == LAST);

  // Consecutive idle-cycle count, restarted by any busy cycle.
  always_ff @(posedge clk) begin
    if (rst || clr || busy) begin
      gap_cnt <= '0;
    end else if (!done) begin
      gap_cnt <= gap_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/failover_ctrl.sv
// Dual-link failover controller: hold-off, drain, switch.
// select only moves once all traffic has been idle long enough.
module failover_ctrl
  import failover_ctrl_pkg::*;
#(
  parameter int HOLDOFF_CYCLES  = 1250,
  parameter int REVERT_CYCLES   = 125000000,
  parameter int REVERT_EN       = 1,
  parameter int IDLE_GAP_CYCLES = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                link_ok1,
  input  logic                link_ok2,
  input  logic                force_en,
  input  logic                force_sel,
  input  logic                up_busy,
  input  logic                p1_busy,
  input  logic                p2_busy,
  output logic                select,
  output logic                switching,
  output logic                fault,
  output logic [SW_CNT_W-1:0] switch_cnt
);

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] REV_LAST =
    CNT_W'(REVERT_CYCLES - 1);
  localparam logic REV_ON = (REVERT_EN != 0);

  fsm_state_t       state;
  logic             tgt;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_last;
  logic             want;
  logic             revert_cause;
  logic             gap_clr;
  logic             any_busy;
  logic             gap_done;

  assign want = want_sel(force_en, force_sel,
                         link_ok1, link_ok2,
                         REV_ON, select);

  assign revert_cause = link_ok1 && link_ok2
                        && !force_en;
  assign hold_last = revert_cause ? REV_LAST
                                  : HOLD_LAST;

  assign gap_clr  = (state != ST_DRAIN);
  assign any_busy = up_busy || p1_busy || p2_busy;

  idle_gap_timer #(
    .GAP_CYCLES(IDLE_GAP_CYCLES)
  ) u_gap (
    .clk  (clk),
    .rst  (rst),
    .clr  (gap_clr),
    .busy (any_busy),
    .done (gap_done)
  );

  // Main FSM: decide, hold off, drain, then switch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_ACTIVE;
      select     <= 1'b0;
      tgt        <= 1'b0;
      hold_cnt   <= '0;
      switching  <= 1'b0;
      switch_cnt <= '0;
    end else begin
      unique case (state)
        ST_ACTIVE: begin
          hold_cnt <= '0;
          if (want != select) begin
            tgt <= want;
            if (force_en) begin
              state     <= ST_DRAIN;
              switching <= 1'b1;
            end else begin
              state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (want != tgt) begin
            state    <= ST_ACTIVE;
            hold_cnt <= '0;
          end else if (force_en ||
                       hold_cnt == hold_last) begin
            state     <= ST_DRAIN;
            switching <= 1'b1;
            hold_cnt  <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (want != tgt) begin
            state     <= ST_ACTIVE;
            switching <= 1'b0;
          end else if (gap_done) begin
            state     <= ST_ACTIVE;
            switching <= 1'b0;
            select    <= tgt;
            if (switch_cnt != '1) begin
              switch_cnt <= switch_cnt + 1'b1;
            end
          end
        end
        default: begin
          state     <= ST_ACTIVE;
          switching <= 1'b0;
          hold_cnt  <= '0;
        end
      endcase
    end
  end

  // Both-links-down flag, one cycle behind the inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault <= 1'b0;
    end else begin
      fault <= !link_ok1 && !link_ok2;
    end
  end

endmodule

// File: tb/tb_failover_ctrl.sv
// Scoreboard bench for failover_ctrl (short timers).
// Expectations are cycle-stamped and checked by a monitor.
module tb_failover_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic link_ok1 = 1'b1;
  logic link_ok2 = 1'b1;
  logic force_en = 1'b0;
  logic force_sel = 1'b0;
  logic up_busy = 1'b0;
  logic p1_busy = 1'b0;
  logic p2_busy = 1'b0;

  logic        select, switching, fault;
  logic [15:0] switch_cnt;
  logic        nr_select, nr_switching, nr_fault;
  logic [15:0] nr_switch_cnt;

  typedef struct {
    int    cyc;
    int    sig;
    int    val;
    string name;
  } exp_t;

  exp_t exq[$];
  int cyc = 0;
  int applied = 0;
  int miscompares = 0;

  localparam int S_SEL = 0;
  localparam int S_SW  = 1;
  localparam int S_FLT = 2;
  localparam int S_CNT = 3;
  localparam int S_NR  = 4;

  failover_ctrl #(
    .HOLDOFF_CYCLES (4),
    .REVERT_CYCLES  (20),
    .REVERT_EN      (1),
    .IDLE_GAP_CYCLES(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .link_ok1  (link_ok1),
    .link_ok2  (link_ok2),
    .force_en  (force_en),
    .force_sel (force_sel),
    .up_busy   (up_busy),
    .p1_busy   (p1_busy),
    .p2_busy   (p2_busy),
    .select    (select),
    .switching (switching),
    .fault     (fault),
    .switch_cnt(switch_cnt)
  );

  failover_ctrl #(
    .HOLDOFF_CYCLES (4),
    .REVERT_CYCLES  (20),
    .REVERT_EN      (0),
    .IDLE_GAP_CYCLES(3)
  ) dut_nr (
    .clk       (clk),
    .rst       (rst),
    .link_ok1  (link_ok1),
    .link_ok2  (link_ok2),
    .force_en  (force_en),
    .force_sel (force_sel),
    .up_busy   (up_busy),
    .p1_busy   (p1_busy),
    .p2_busy   (p2_busy),
    .select    (nr_select),
    .switching (nr_switching),
    .fault     (nr_fault),
    .switch_cnt(nr_switch_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int actual(int sig);
    case (sig)
      S_SEL:   return int'(select);
      S_SW:    return int'(switching);
      S_FLT:   return int'(fault);
      S_CNT:   return int'(switch_cnt);
      default: return int'(nr_select);
    endcase
  endfunction

  function automatic void chk(int dc, int sig,
                              int val, string nm);
    exp_t e;
    e.cyc  = cyc + dc;
    e.sig  = sig;
    e.val  = val;
    e.name = nm;
    exq.push_back(e);
  endfunction

  task automatic go(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    go(1);
    rst = 1'b0;
    go(1);
  endtask

  always @(negedge clk) begin
    for (int i = exq.size() - 1; i >= 0; i--) begin
      if (exq[i].cyc == cyc) begin
        int a;
        a = actual(exq[i].sig);
        applied++;
        if (a != exq[i].val) begin
          miscompares++;
          $display("FAIL %s cyc=%0d got=%0d want=%0d",
                   exq[i].name, cyc, a, exq[i].val);
        end
        exq.delete(i);
      end
    end
  end

  initial begin
    go(1);
    chk(1, S_SEL, 0, "rst_select");
    chk(1, S_SW, 0, "rst_switching");
    chk(1, S_FLT, 0, "rst_fault");
    chk(1, S_CNT, 0, "rst_cnt");
    go(1);
    rst = 1'b0;
    go(1);
    if (select !== 1'b0) begin
      miscompares++;
      $display("FAIL init_sel got=%0b", select);
    end
    if (switch_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL init_cnt got=%0d", switch_cnt);
    end

    // port-1 down long enough: failover, then revert
    link_ok1 = 1'b0;
    chk(1, S_SW, 0, "a_hold_no_sw");
    chk(4, S_SW, 0, "a_pre_drain");
    chk(5, S_SW, 1, "a_drain");
    chk(7, S_SEL, 0, "a_sel_pre");
    chk(8, S_SEL, 1, "a_sel");
    chk(8, S_CNT, 1, "a_cnt");
    chk(8, S_SW, 0, "a_sw_done");
    chk(8, S_NR, 1, "a_nr_sel");
    go(10);
    link_ok1 = 1'b1;
    chk(23, S_SEL, 1, "a_rev_pre");
    chk(24, S_SEL, 0, "a_revert");
    chk(24, S_CNT, 2, "a_rev_cnt");
    chk(30, S_NR, 1, "a_nr_hold");
    go(32);
    do_reset();

    // two-cycle glitch never reaches DRAIN
    link_ok1 = 1'b0;
    chk(4, S_SW, 0, "b_sw4");
    chk(5, S_SW, 0, "b_no_drain");
    chk(6, S_SW, 0, "b_sw6");
    chk(8, S_SEL, 0, "b_sel");
    chk(8, S_CNT, 0, "b_cnt");
    go(2);
    link_ok1 = 1'b1;
    go(10);

    // force asserted while in HOLD jumps to DRAIN
    link_ok1 = 1'b0;
    go(1);
    force_en = 1'b1;
    force_sel = 1'b1;
    chk(1, S_SW, 1, "h_force_drain");
    chk(3, S_SEL, 0, "h_sel_pre");
    chk(4, S_SEL, 1, "h_sel");
    chk(4, S_CNT, 1, "h_cnt");
    go(6);
    force_en = 1'b0;
    link_ok1 = 1'b1;
    do_reset();

    // busy port keeps DRAIN open until idle gap
    p1_busy = 1'b1;
    link_ok1 = 1'b0;
    chk(5, S_SW, 1, "c_drain");
    chk(30, S_SW, 1, "c_sw_mid");
    chk(50, S_SW, 1, "c_sw_busy_end");
    chk(50, S_SEL, 0, "c_sel_busy");
    go(50);
    p1_busy = 1'b0;
    chk(2, S_SW, 1, "c_sw_gap");
    chk(2, S_SEL, 0, "c_sel_pre");
    chk(3, S_SEL, 1, "c_sel");
    chk(3, S_CNT, 1, "c_cnt");
    go(6);

    // both links down: fault, select held at 1
    link_ok2 = 1'b0;
    chk(1, S_FLT, 1, "d_fault");
    chk(5, S_SW, 0, "d_no_sw");
    chk(10, S_SEL, 1, "d_sel_hold");
    go(10);

    // reset during DRAIN discards the switch
    link_ok1 = 1'b1;
    p2_busy = 1'b1;
    chk(1, S_FLT, 0, "g_fault_clr");
    chk(6, S_SW, 1, "g_drain");
    chk(7, S_SEL, 1, "g_sel_pre");
    go(7);
    rst = 1'b1;
    chk(1, S_SEL, 0, "g_rst_sel");
    chk(1, S_SW, 0, "g_rst_sw");
    chk(1, S_CNT, 0, "g_rst_cnt");
    go(1);
    if (select !== 1'b0 || switching !== 1'b0) begin
      miscompares++;
      $display("FAIL g_rst_direct sel=%0b sw=%0b",
               select, switching);
    end
    rst = 1'b0;
    link_ok2 = 1'b1;
    p2_busy = 1'b0;
    go(2);

    // forced switch skips hold-off
    force_en = 1'b1;
    force_sel = 1'b1;
    chk(1, S_SW, 1, "e_drain_next");
    chk(3, S_SEL, 0, "e_sel_pre");
    chk(4, S_SEL, 1, "e_sel");
    chk(4, S_CNT, 1, "e_cnt");
    go(6);
    force_en = 1'b0;
    do_reset();

    // force drop on the gap-done cycle: abort wins
    force_en = 1'b1;
    force_sel = 1'b1;
    chk(1, S_SW, 1, "e2_drain");
    chk(3, S_SW, 1, "e2_still");
    go(3);
    force_en = 1'b0;
    chk(1, S_SW, 0, "e2_abort_sw");
    chk(2, S_SEL, 0, "e2_abort_sel");
    chk(2, S_CNT, 0, "e2_abort_cnt");
    go(5);
    if (select !== 1'b0) begin
      miscompares++;
      $display("FAIL e2_end_sel got=%0b", select);
    end
    if (switch_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL e2_end_cnt got=%0d", switch_cnt);
    end

    foreach (exq[i]) begin
      miscompares++;
      $display("FAIL %s never checked (cyc=%0d)",
               exq[i].name, exq[i].cyc);
    end
    if (applied < 12) begin
      miscompares++;
      $display("FAIL too few vectors %0d", applied);
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miscompares);
    $finish;
  end

endmodule
